pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, range 1..255: maximum consecutive memory-stall cycles before watchdog trip.
REQ-002 SHALL have port dclk, input, 1, the single pipeline clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset: asserted at 0, released synchronously to dclk.
REQ-004 SHALL have port stallreq_id, input, 1, load-use hazard from ID.
REQ-005 SHALL have port stallreq_mem, input, 1, memory stage busy.
REQ-006 SHALL have port branch_ex, input, 1, taken branch/jump resolved in EX.
REQ-007 SHALL have port target_ex, input, 32, branch target address.
REQ-008 SHALL have port halt_req, input, 1, ebreak/debug halt request.
REQ-009 SHALL have port resume, input, 1, single-cycle pulse that leaves HALT.
REQ-010 SHALL have port stall, output, 5, hold enables for [0]pc, [1]if_id, [2]id_ex, [3]ex_mem, [4]mem_wb.
REQ-011 SHALL have port flush, output, 5, bubble-insert enables with the same bit map.
REQ-012 SHALL have port pc_redirect, output, 1, PC load strobe.
REQ-013 SHALL have port redirect_pc, output, 32, PC load value.
REQ-014 SHALL have port halted, output, 1, high while in HALT.
REQ-015 SHALL have port err_timeout, output, 1, sticky watchdog error.
REQ-016 SHALL have port stall_cnt, output, 32, performance count of cycles with stall[0]=1.

Function
REQ-017 SHALL implement states RUN, MEMWAIT and HALT; stall, flush and redirect SHALL be combinational from the current state and inputs, valid in the same cycle.
REQ-018 SHALL, in RUN/MEMWAIT with stallreq_mem=1, drive stall=5'b01111, flush=5'b10000 and pc_redirect=0, moving RUN->MEMWAIT.
REQ-019 SHALL, with stallreq_mem=0 and branch_ex=1, drive stall=0, flush=5'b00110, pc_redirect=1 and redirect_pc=target_ex.
REQ-020 SHALL, with stallreq_mem=0, branch_ex=0 and stallreq_id=1, drive stall=5'b00011 and flush=5'b00100.
REQ-021 SHALL use priority stallreq_mem > branch_ex > stallreq_id; a deferred branch stays asserted by EX because id_ex and ex_mem are held.
REQ-022 SHALL drive stall=0, flush=0 and pc_redirect=0 when there is no request; redirect_pc SHALL equal target_ex at all times.
REQ-023 SHALL count consecutive MEMWAIT cycles in an 8-bit counter, cleared on MEMWAIT exit, returning to RUN the cycle after stallreq_mem falls.
REQ-024 SHALL, when the MEMWAIT counter reaches TIMEOUT while stallreq_mem=1, set err_timeout and enter HALT on the next edge.
REQ-025 SHALL enter HALT from RUN on halt_req=1 only when stallreq_mem=0; a same-cycle branch_ex is still redirected that cycle.
REQ-026 SHALL, in HALT, drive stall=5'b11111, flush=0 and pc_redirect=0, ignoring every request except resume.
REQ-027 SHALL go HALT->RUN on resume=1; resume in other states has no effect; err_timeout stays set.
REQ-028 SHALL increment stall_cnt by 1 on every edge where stall[0]=1, wrapping 0xFFFFFFFF->0.

Reset
REQ-029 SHALL, while rst=0, force state=RUN, MEMWAIT counter=0, err_timeout=0, halted=0, stall_cnt=0, stall=0, flush=0 and pc_redirect=0.
REQ-030 SHALL make rst=0 mid-MEMWAIT or mid-HALT return to RUN immediately, with no residual stall.

Structure
REQ-031 SHALL take stall/flush bit indices, state encoding and ZeroWord from the shared package pipe_pkg.
REQ-032 SHALL place the MEMWAIT counter and timeout compare in one sub-module, pipe_watchdog.

Verification
REQ-033 SHALL test: branch_ex=1, target_ex=0x0000_0100 -> same cycle flush=00110, pc_redirect=1, redirect_pc=0x100.
REQ-034 SHALL test: stallreq_id=1 for 1 cycle -> stall=00011, flush=00100, stall_cnt +1.
REQ-035 SHALL test: stallreq_mem=1 with branch_ex=1 for 3 cycles -> stall=01111 ×3, no redirect; the 4th cycle with mem=0 redirects.
REQ-036 SHALL test: TIMEOUT=4 and stallreq_mem held high -> err_timeout=1 and halted=1 after the 4th MEMWAIT cycle, stall=11111.
REQ-037 SHALL test: halt_req, 5 idle cycles, then resume -> halted for 5 cycles, RUN next, stall_cnt=5.
REQ-038 SHALL test: rst=0 asserted mid-MEMWAIT -> all outputs 0 asynchronously, RUN after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - stage bit indices for the stall/flush vectors
//   - controller state encoding
//   - stage masks and the per-cycle control bundle
package pipe_pkg;

  localparam int NSTG      = 5;
  localparam int IDX_PC    = 0;
  localparam int IDX_IFID  = 1;
  localparam int IDX_IDEX  = 2;
  localparam int IDX_EXMEM = 3;
  localparam int IDX_MEMWB = 4;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [NSTG-1:0] M_PC    = NSTG'(1 << IDX_PC);
  localparam logic [NSTG-1:0] M_IFID  = NSTG'(1 << IDX_IFID);
  localparam logic [NSTG-1:0] M_IDEX  = NSTG'(1 << IDX_IDEX);
  localparam logic [NSTG-1:0] M_EXMEM = NSTG'(1 << IDX_EXMEM);
  localparam logic [NSTG-1:0] M_MEMWB = NSTG'(1 << IDX_MEMWB);
  localparam logic [NSTG-1:0] M_ALL   = M_PC | M_IFID | M_IDEX | M_EXMEM | M_MEMWB;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [NSTG-1:0] stall;
    logic [NSTG-1:0] flush;
    logic            redirect;
  } pipe_ctl_t;

endpackage

// File: rtl/pipe_watchdog.sv
// Memory-stall watchdog.
//   dclk    : pipeline clock
//   rst     : async active-low reset
//   in_wait : controller is in MEMWAIT
//   busy    : memory stage still busy this cycle
//   trip    : this cycle is the TIMEOUT-th consecutive MEMWAIT cycle with busy high
module pipe_watchdog
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic dclk,
  input  logic rst,
  input  logic in_wait,
  input  logic busy,
  output logic trip
);

  // cnt holds the number of MEMWAIT cycles already completed; the
  // current cycle is number cnt+1, so the compare is against TIMEOUT-1.
  logic [7:0] cnt;

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst)                          cnt <= '0;
    else if (in_wait && busy) begin
      if (cnt != 8'hFF)                cnt <= cnt + 8'd1;
    end
    else                               cnt <= '0;
  end

  assign trip = in_wait && busy && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard / halt controller.
//   dclk, rst        : clock, async active-low reset
//   stallreq_id      : load-use hazard from ID
//   stallreq_mem     : memory stage busy
//   branch_ex        : taken branch resolved in EX, target in target_ex
//   halt_req, resume : debug halt entry / single-cycle exit pulse
//   stall, flush     : per-stage hold / bubble enables ([0]pc .. [4]mem_wb)
//   pc_redirect      : PC load strobe, redirect_pc = load value
//   halted           : in HALT
//   err_timeout      : sticky watchdog error
//   stall_cnt        : cycles with stall[0]=1
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            dclk,
  input  logic            rst,
  input  logic            stallreq_id,
  input  logic            stallreq_mem,
  input  logic            branch_ex,
  input  logic [31:0]     target_ex,
  input  logic            halt_req,
  input  logic            resume,
  output logic [NSTG-1:0] stall,
  output logic [NSTG-1:0] flush,
  output logic            pc_redirect,
  output logic [31:0]     redirect_pc,
  output logic            halted,
  output logic            err_timeout,
  output logic [31:0]     stall_cnt
);

  pipe_state_e state, nxt;
  pipe_ctl_t   ctl;
  logic        trip;

  pipe_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .dclk    (dclk),
    .rst     (rst),
    .in_wait (state == ST_MEMWAIT),
    .busy    (stallreq_mem),
    .trip    (trip)
  );

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= nxt;
  end

  always_comb begin
    ctl = '0;
    nxt = state;
    case (state)
      ST_HALT: begin
        ctl.stall = M_ALL;
        if (resume) nxt = ST_RUN;
      end
      ST_RUN, ST_MEMWAIT: begin
        if (stallreq_mem) begin
          // Hold everything up to ex_mem; a branch in EX stays put and is
          // taken once memory frees up.
          ctl.stall = M_PC | M_IFID | M_IDEX | M_EXMEM;
          ctl.flush = M_MEMWB;
          nxt       = trip ? ST_HALT : ST_MEMWAIT;
        end
        else begin
          if (branch_ex) begin
            ctl.flush    = M_IFID | M_IDEX;
            ctl.redirect = 1'b1;
          end
          else if (stallreq_id) begin
            ctl.stall = M_PC | M_IFID;
            ctl.flush = M_IDEX;
          end
          nxt = (state == ST_RUN && halt_req) ? ST_HALT : ST_RUN;
        end
      end
      default: nxt = ST_RUN;
    endcase
  end

  // Reset masks the combinational controls so no stall leaks out while rst=0.
  assign stall       = rst ? ctl.stall    : '0;
  assign flush       = rst ? ctl.flush    : '0;
  assign pc_redirect = rst ? ctl.redirect : 1'b0;
  assign redirect_pc = target_ex;
  assign halted      = (state == ST_HALT);

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst)      err_timeout <= 1'b0;
    else if (trip) err_timeout <= 1'b1;
  end

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst)                stall_cnt <= ZeroWord;
    else if (stall[IDX_PC])  stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        dclk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_mem, branch_ex, halt_req, resume;
  logic [31:0] target_ex;
  logic [4:0]  stall, flush;
  logic        pc_redirect, halted, err_timeout;
  logic [31:0] redirect_pc, stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 dclk = ~dclk;

  pipe_ctrl #(.TIMEOUT(4)) dut (
    .dclk(dclk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
    .branch_ex(branch_ex), .target_ex(target_ex),
    .halt_req(halt_req), .resume(resume),
    .stall(stall), .flush(flush),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .halted(halted), .err_timeout(err_timeout), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // advance one edge, land 1 time unit after it
  task automatic step();
    @(posedge dclk); #1;
  endtask

  task automatic idle();
    stallreq_id = 0; stallreq_mem = 0; branch_ex = 0; halt_req = 0; resume = 0;
  endtask

  task automatic do_reset();
    rst = 0; #3; step(); rst = 1; #1;
  endtask

  initial begin
    idle(); target_ex = 32'h0;
    rst = 0;
    stallreq_mem = 1;   // controls must stay 0 under reset regardless
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_redir", 32'(pc_redirect), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_cnt", stall_cnt, 0);
    idle();
    step(); rst = 1; #1;

    // branch redirect, same cycle
    branch_ex = 1; target_ex = 32'h0000_0100; #1;
    chk("br_stall", 32'(stall), 0);
    chk("br_flush", 32'(flush), 32'h06);
    chk("br_redir", 32'(pc_redirect), 1);
    chk("br_pc", redirect_pc, 32'h100);
    step(); idle(); #1;
    chk("idle_stall", 32'(stall), 0);
    chk("idle_flush", 32'(flush), 0);
    chk("idle_redir", 32'(pc_redirect), 0);
    target_ex = 32'hDEAD_BEEF; #1;
    chk("idle_pc", redirect_pc, 32'hDEAD_BEEF);

    // load-use stall for one cycle
    stallreq_id = 1; #1;
    chk("id_stall", 32'(stall), 32'h03);
    chk("id_flush", 32'(flush), 32'h04);
    step(); idle(); #1;
    chk("id_cnt", stall_cnt, 1);

    // mem stall beats branch for 3 cycles, branch taken on the 4th
    target_ex = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      stallreq_mem = 1; branch_ex = 1; #1;
      chk($sformatf("mb_stall%0d", i), 32'(stall), 32'h0F);
      chk($sformatf("mb_flush%0d", i), 32'(flush), 32'h10);
      chk($sformatf("mb_redir%0d", i), 32'(pc_redirect), 0);
      step();
    end
    stallreq_mem = 0; #1;
    chk("mb4_redir", 32'(pc_redirect), 1);
    chk("mb4_flush", 32'(flush), 32'h06);
    chk("mb4_stall", 32'(stall), 0);
    step(); idle(); #1;
    chk("mb_cnt", stall_cnt, 4);
    chk("mb_err", 32'(err_timeout), 0);
    // back in RUN: halt_req is honoured
    halt_req = 1; step(); idle(); #1;
    chk("mb_run", 32'(halted), 1);
    resume = 1; step(); idle(); #1;
    chk("mb_resume", 32'(halted), 0);

    // watchdog: TIMEOUT=4, mem held
    do_reset();
    stallreq_mem = 1;
    step();                       // RUN -> MEMWAIT
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("wd_err_c%0d", i), 32'(err_timeout), 0);
      chk($sformatf("wd_halt_c%0d", i), 32'(halted), 0);
    end
    step();                       // end of 4th MEMWAIT cycle
    chk("wd_err", 32'(err_timeout), 1);
    chk("wd_halted", 32'(halted), 1);
    branch_ex = 1; stallreq_id = 1; #1;
    chk("wd_stall", 32'(stall), 32'h1F);
    chk("wd_flush", 32'(flush), 0);
    chk("wd_redir", 32'(pc_redirect), 0);
    step();
    chk("wd_still", 32'(halted), 1);
    idle(); resume = 1; step(); idle(); #1;
    chk("wd_resume", 32'(halted), 0);
    chk("wd_sticky", 32'(err_timeout), 1);
    resume = 1; step(); idle(); #1;
    chk("res_in_run", 32'(halted), 0);

    // halt with same-cycle branch, 5 halted cycles, resume in the last
    do_reset();
    halt_req = 1; branch_ex = 1; target_ex = 32'h0000_0040; #1;
    chk("hb_redir", 32'(pc_redirect), 1);
    chk("hb_pc", redirect_pc, 32'h40);
    step(); idle();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) resume = 1;
      #1;
      chk($sformatf("h_halted%0d", i), 32'(halted), 1);
      chk($sformatf("h_stall%0d", i), 32'(stall), 32'h1F);
      step();
    end
    idle(); #1;
    chk("h_run", 32'(halted), 0);
    chk("h_cnt", stall_cnt, 5);
    chk("h_err", 32'(err_timeout), 0);

    // async reset in the middle of MEMWAIT
    stallreq_mem = 1; step(); step(); #2;
    chk("mr_pre", 32'(stall), 32'h0F);
    rst = 0; #1;
    chk("mr_stall", 32'(stall), 0);
    chk("mr_flush", 32'(flush), 0);
    chk("mr_cnt", stall_cnt, 0);
    chk("mr_halted", 32'(halted), 0);
    step(); idle(); rst = 1; #1;
    chk("mr_rel_stall", 32'(stall), 0);
    halt_req = 1; step(); idle(); #1;
    chk("mr_run", 32'(halted), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
